// File: rtl/push_btn_bank_pkg.sv
// Shared encodings for the push-button bank: opcodes, edge-qualification modes, controller states.
package push_btn_bank_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RBS = 4'h1;
  localparam logic [3:0] OP_RAS = 4'h2;
  localparam logic [3:0] OP_SEM = 4'h3;
  localparam logic [3:0] OP_CLR = 4'h4;

  localparam logic [1:0] MODE_PRESS   = 2'b00;
  localparam logic [1:0] MODE_RELEASE = 2'b01;
  localparam logic [1:0] MODE_BOTH    = 2'b10;
  localparam logic [1:0] MODE_LEVEL   = 2'b11;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_ERROR = 1'b1
  } state_e;

  // Edge event that a channel in the given mode latches into its sticky bit.
  function automatic logic qualify(input logic [1:0] mode, input logic rise, input logic fall);
    logic hit;
    case (mode)
      MODE_PRESS:   hit = rise;
      MODE_RELEASE: hit = fall;
      MODE_BOTH:    hit = rise | fall;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/push_btn_bank_btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced level and registered edge pulses.
module btn_debounce #(
  parameter int DebounceCycles = 16,
  parameter int CntWidth       = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [1:0]          sync_q, sync_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                stable_q, stable_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  // With en_i low every register holds, freezing the channel.
  always_comb begin
    sync_d   = sync_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    if (en_i) begin
      sync_d = {sync_q[0], raw_i};
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        stable_d = sync_q[1];
        cnt_d    = '0;
        rise_d   = sync_q[1];
        fall_d   = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end else begin
      sync_d = sync_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/push_btn_bank.sv
// Multi-channel push-button controller: per-channel debouncers, sticky event bits, instruction decode and error lock.
module push_btn_bank
  import push_btn_bank_pkg::*;
#(
  parameter int Channels       = 4,
  parameter int DebounceCycles = 16,
  parameter int CntWidth       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         inst,
  input  logic                inst_en,
  input  logic [Channels-1:0] buttons,
  output logic                button_status,
  output logic [Channels-1:0] status_vec,
  output logic                error
);

  localparam logic [7:0] LegalMask = 8'((9'd1 << Channels) - 9'd1);

  state_e                    state_q, state_d;
  logic                      bs_q, bs_d;
  logic [Channels-1:0]       vec_q, vec_d;
  logic                      err_q, err_d;
  logic [Channels-1:0]       sticky_q, sticky_d;
  logic [Channels-1:0][1:0]  mode_q, mode_d;

  logic [Channels-1:0] stable_s, rise_s, fall_s;
  logic [Channels-1:0] ch_oh_s, level_s, clr_s, mask_s;
  logic                bad_ch_s, bad_mask_s, fail_s, run_s;

  assign run_s      = (state_q == ST_READY);
  assign bad_ch_s   = ({29'd0, inst[2:0]} >= 32'(Channels));
  assign bad_mask_s = |(inst[7:0] & ~LegalMask);
  assign mask_s     = inst[Channels-1:0];

  for (genvar g = 0; g < Channels; g++) begin : g_deb
    btn_debounce #(
      .DebounceCycles(DebounceCycles),
      .CntWidth      (CntWidth)
    ) u_deb (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (run_s),
      .raw_i   (buttons[g]),
      .stable_o(stable_s[g]),
      .rise_o  (rise_s[g]),
      .fall_o  (fall_s[g])
    );
  end

  // Channel select and LEVEL-mode flags.
  always_comb begin
    ch_oh_s = '0;
    level_s = '0;
    for (int c = 0; c < Channels; c++) begin
      ch_oh_s[c] = (inst[2:0] == 3'(c));
      level_s[c] = (mode_q[c] == MODE_LEVEL);
    end
  end

  // Decode, state machine and sticky update; a qualified edge wins over a same-cycle clear.
  always_comb begin
    state_d  = state_q;
    bs_d     = bs_q;
    vec_d    = vec_q;
    err_d    = err_q;
    mode_d   = mode_q;
    sticky_d = sticky_q;
    clr_s    = '0;
    fail_s   = 1'b0;
    if (state_q == ST_READY) begin
      if (inst_en) begin
        case (inst[11:8])
          OP_NOP: fail_s = 1'b0;
          OP_RBS: begin
            if (bad_ch_s) begin
              fail_s = 1'b1;
            end else begin
              bs_d  = |(sticky_q & ch_oh_s);
              clr_s = ch_oh_s & ~level_s;
            end
          end
          OP_RAS: begin
            if (bad_mask_s) begin
              fail_s = 1'b1;
            end else begin
              vec_d = sticky_q & mask_s;
              bs_d  = |(sticky_q & mask_s);
              clr_s = mask_s & ~level_s;
            end
          end
          OP_SEM: begin
            if (bad_ch_s) begin
              fail_s = 1'b1;
            end else begin
              clr_s = ch_oh_s;
              for (int c = 0; c < Channels; c++) begin
                if (ch_oh_s[c]) begin
                  mode_d[c] = inst[5:4];
                end else begin
                  mode_d[c] = mode_q[c];
                end
              end
            end
          end
          OP_CLR:  clr_s  = '1;
          default: fail_s = 1'b1;
        endcase
      end else begin
        fail_s = 1'b0;
      end
      if (fail_s) begin
        state_d = ST_ERROR;
        bs_d    = 1'b0;
        vec_d   = '0;
        err_d   = 1'b1;
      end else begin
        state_d = ST_READY;
      end
      for (int c = 0; c < Channels; c++) begin
        if (level_s[c]) begin
          sticky_d[c] = stable_s[c] & ~clr_s[c];
        end else begin
          sticky_d[c] = qualify(mode_q[c], rise_s[c], fall_s[c]) | (sticky_q[c] & ~clr_s[c]);
        end
      end
    end else begin
      state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_READY;
      bs_q     <= 1'b0;
      vec_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= '0;
      mode_q   <= {Channels{MODE_PRESS}};
    end else begin
      state_q  <= state_d;
      bs_q     <= bs_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      mode_q   <= mode_d;
    end
  end

  assign button_status = bs_q;
  assign status_vec    = vec_q;
  assign error         = err_q;

endmodule

// File: tb/tb_push_btn_bank.sv
// Bench for push_btn_bank: directed stimulus, per-cycle comparison against a behavioural model, literal spot checks.
module tb_push_btn_bank;

  localparam int CH  = 4;
  localparam int DEB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   inst;
  logic          inst_en;
  logic [CH-1:0] buttons;
  logic          button_status;
  logic [CH-1:0] status_vec;
  logic          error;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  push_btn_bank #(
    .Channels      (CH),
    .DebounceCycles(DEB),
    .CntWidth      (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .inst         (inst),
    .inst_en      (inst_en),
    .buttons      (buttons),
    .button_status(button_status),
    .status_vec   (status_vec),
    .error        (error)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: a level is accepted once DEB consecutive synchronised samples disagree with it.
  bit           m_valid = 1'b0;
  bit           m_err, m_bs;
  bit [CH-1:0]  m_vec, m_sticky, m_stable, m_rise, m_fall, m_p1, m_p2;
  bit [1:0]     m_mode [CH];
  bit [DEB-1:0] m_win  [CH];

  always @(posedge clock) begin : model
    bit [CH-1:0] clr;
    bit          to_err, sem, ev;
    int          ch;
    clr = '0; to_err = 1'b0; sem = 1'b0; ch = int'(inst[2:0]);
    if (reset) begin
      m_valid = 1'b1; m_err = 1'b0; m_bs = 1'b0; m_vec = '0;
      m_sticky = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_p1 = '0; m_p2 = '0;
      for (int c = 0; c < CH; c++) begin m_mode[c] = 2'd0; m_win[c] = '0; end
    end else if (m_valid && !m_err) begin
      if (inst_en) begin
        case (inst[11:8])
          4'h0: ;
          4'h1: if (ch >= CH) to_err = 1'b1;
                else begin m_bs = m_sticky[ch]; if (m_mode[ch] != 2'd3) clr[ch] = 1'b1; end
          4'h2: if (inst[7:CH] != '0) to_err = 1'b1;
                else begin
                  m_vec = m_sticky & inst[CH-1:0];
                  m_bs  = (m_vec != '0);
                  for (int c = 0; c < CH; c++) if (inst[c] && m_mode[c] != 2'd3) clr[c] = 1'b1;
                end
          4'h3: if (ch >= CH) to_err = 1'b1; else begin clr[ch] = 1'b1; sem = 1'b1; end
          4'h4: clr = '1;
          default: to_err = 1'b1;
        endcase
      end
      for (int c = 0; c < CH; c++) begin
        if (m_mode[c] == 2'd3) m_sticky[c] = m_stable[c] && !clr[c];
        else begin
          ev = (m_mode[c] == 2'd0 && m_rise[c]) || (m_mode[c] == 2'd1 && m_fall[c]) ||
               (m_mode[c] == 2'd2 && (m_rise[c] || m_fall[c]));
          m_sticky[c] = ev || (m_sticky[c] && !clr[c]);
        end
      end
      if (sem) m_mode[ch] = inst[5:4];
      for (int c = 0; c < CH; c++) begin
        m_win[c]  = {m_win[c][DEB-2:0], m_p2[c]};
        m_rise[c] = 1'b0; m_fall[c] = 1'b0;
        if (m_win[c] == {DEB{~m_stable[c]}}) begin
          m_stable[c] = m_p2[c];
          m_rise[c]   = m_p2[c];
          m_fall[c]   = !m_p2[c];
        end
      end
      m_p2 = m_p1;
      m_p1 = buttons;
      if (to_err) begin m_err = 1'b1; m_bs = 1'b0; m_vec = '0; end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      check("cyc_button_status", {7'd0, button_status}, {7'd0, m_bs});
      check("cyc_status_vec", {4'd0, status_vec}, {4'd0, m_vec});
      check("cyc_error", {7'd0, error}, {7'd0, m_err});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] imm);
    inst    = {op, imm};
    inst_en = 1'b1;
    @(posedge clock);
    #1;
    inst_en = 1'b0;
    inst    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inst_en = 1'b0; inst = '0; buttons = '0;
    tick(3);
    reset = 1'b0;
    check("reset_error", {7'd0, error}, 8'd0);
    check("reset_status", {7'd0, button_status}, 8'd0);
    check("reset_vec", {4'd0, status_vec}, 8'd0);

    issue(4'h0, 8'h00);
    issue(4'h1, 8'h00); check("idle_rbs0_a", {7'd0, button_status}, 8'd0);
    issue(4'h1, 8'h00); check("idle_rbs0_b", {7'd0, button_status}, 8'd0);
    check("idle_error", {7'd0, error}, 8'd0);

    buttons[1] = 1'b1;
    tick(7);
    issue(4'h1, 8'h01); check("held_first_read", {7'd0, button_status}, 8'd1);
    repeat (4) begin
      tick(3);
      issue(4'h1, 8'h01); check("held_later_read", {7'd0, button_status}, 8'd0);
    end
    buttons[1] = 1'b0;
    tick(10);
    issue(4'h1, 8'h01); check("release_press_mode", {7'd0, button_status}, 8'd0);

    buttons[2] = 1'b1; tick(3); buttons[2] = 1'b0;
    tick(10);
    issue(4'h1, 8'h02); check("glitch_rejected", {7'd0, button_status}, 8'd0);
    buttons[2] = 1'b1; tick(6); buttons[2] = 1'b0;
    tick(10);
    issue(4'h1, 8'h02); check("long_press_seen", {7'd0, button_status}, 8'd1);

    issue(4'h3, 8'h13);
    buttons[3] = 1'b1; tick(8); buttons[3] = 1'b0;
    tick(10);
    issue(4'h2, 8'h0F);
    check("ras_release_vec", {4'd0, status_vec}, 8'h08);
    check("ras_release_bs", {7'd0, button_status}, 8'd1);
    issue(4'h2, 8'h0F);
    check("ras_repeat_vec", {4'd0, status_vec}, 8'h00);
    check("ras_repeat_bs", {7'd0, button_status}, 8'd0);

    buttons[0] = 1'b1;
    tick(6);
    issue(4'h1, 8'h00); check("same_cycle_old", {7'd0, button_status}, 8'd0);
    issue(4'h1, 8'h00); check("same_cycle_kept", {7'd0, button_status}, 8'd1);

    issue(4'h3, 8'h30);
    tick(2);
    issue(4'h1, 8'h00); check("level_read_a", {7'd0, button_status}, 8'd1);
    issue(4'h1, 8'h00); check("level_read_b", {7'd0, button_status}, 8'd1);
    issue(4'h4, 8'h00); check("clr_keeps_output", {7'd0, button_status}, 8'd1);

    issue(4'hB, 8'hAE);
    check("bad_op_error", {7'd0, error}, 8'd1);
    check("bad_op_status", {7'd0, button_status}, 8'd0);
    issue(4'h1, 8'h00);
    check("error_ignores_rbs", {7'd0, button_status}, 8'd0);
    check("error_sticks", {7'd0, error}, 8'd1);

    do_reset();
    check("reset_clears_error", {7'd0, error}, 8'd0);
    tick(8);
    issue(4'h1, 8'h00); check("post_reset_rbs0", {7'd0, button_status}, 8'd1);
    issue(4'h1, 8'h05); check("bad_channel_error", {7'd0, error}, 8'd1);
    do_reset();
    issue(4'h2, 8'h10); check("bad_mask_error", {7'd0, error}, 8'd1);
    do_reset();
    issue(4'h3, 8'h04); check("bad_sem_ch_error", {7'd0, error}, 8'd1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
